// File: rtl/axil_ctrl_regfile_if.sv
// AXI-Lite slave bus bundle (32-bit data) for axil_ctrl_regfile.
// The master modport is the PS/interconnect side; the slave modport is the register file.
interface axil_ctrl_regfile_if #(
    parameter int ADDR_WIDTH = 8
);
    logic [ADDR_WIDTH-1:0] awaddr;
    logic [2:0]            awprot;
    logic                  awvalid;
    logic                  awready;
    logic [31:0]           wdata;
    logic [3:0]            wstrb;
    logic                  wvalid;
    logic                  wready;
    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  bready;
    logic [ADDR_WIDTH-1:0] araddr;
    logic [2:0]            arprot;
    logic                  arvalid;
    logic                  arready;
    logic [31:0]           rdata;
    logic [1:0]            rresp;
    logic                  rvalid;
    logic                  rready;

    modport master (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        output araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        input  araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axil_ctrl_regfile.sv
// Generic AXI-Lite control/status register file.
// NUM_REGS 32-bit registers, each RW (PS-owned), RO (PL-owned) or W1C (PL sets, PS clears),
// with PL write ports, registered PS-write pulses and a registered masked interrupt.
// Optional build macro AXIL_REGFILE_DECERR_EN: out-of-range accesses answer SLVERR (2'b10)
// instead of OKAY.
module axil_ctrl_regfile #(
    parameter int          ADDR_WIDTH      = 8,
    parameter int          NUM_REGS        = 16,
    parameter logic [63:0] RO_MASK         = '0,
    parameter logic [63:0] W1C_MASK        = '0,
    parameter int          IRQ_STS_IDX     = 0,
    parameter int          IRQ_ENA_IDX     = 1,
    parameter int          PIPELINE_OUTPUT = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    axil_ctrl_regfile_if.slave       s_axil,
    input  logic [NUM_REGS-1:0]      pl_wr_en,
    input  logic [32*NUM_REGS-1:0]   pl_wr_data,
    output logic [32*NUM_REGS-1:0]   reg_q,
    output logic [NUM_REGS-1:0]      ps_wr_pulse,
    output logic                     irq
);
    localparam int IDX_W = ADDR_WIDTH - 2;
    localparam bit PIPE  = (PIPELINE_OUTPUT != 0);

    // Register array and its next state
    logic [31:0] regs_q [NUM_REGS];
    logic [31:0] regs_d [NUM_REGS];

    // Write channel state
    logic        awready_q, awready_d;
    logic        bvalid_q,  bvalid_d;
    logic [1:0]  bresp_q,   bresp_d;

    // Read channel state (s1_* is the optional extra pipeline stage)
    logic        arready_q, arready_d;
    logic        rvalid_q,  rvalid_d;
    logic [31:0] rdata_q,   rdata_d;
    logic [1:0]  rresp_q,   rresp_d;
    logic        s1_valid_q, s1_valid_d;
    logic [31:0] s1_data_q,  s1_data_d;
    logic [1:0]  s1_resp_q,  s1_resp_d;

    logic [NUM_REGS-1:0] ps_wr_pulse_q, ps_wr_pulse_d;
    logic                irq_q, irq_d;

    logic [IDX_W-1:0]    wr_idx, rd_idx;
    logic                wr_accept, wr_fire, rd_accept, rd_fire, out_free;
    logic [31:0]         wmask, ps_data, rd_word;
    logic [1:0]          wr_resp, rd_resp;
    logic [NUM_REGS-1:0] ps_sel;
    logic                unused_bits;

    assign wr_idx = s_axil.awaddr[ADDR_WIDTH-1:2];
    assign rd_idx = s_axil.araddr[ADDR_WIDTH-1:2];

    // Address phase ready is a one-cycle pulse; the handshake completes in the cycle it is high.
    assign wr_accept = s_axil.awvalid & s_axil.wvalid & (~bvalid_q | s_axil.bready) & ~awready_q;
    assign wr_fire   = awready_q & s_axil.awvalid & s_axil.wvalid;
    assign out_free  = ~rvalid_q | s_axil.rready;
    assign rd_accept = s_axil.arvalid & ~arready_q & out_free & (~PIPE | ~s1_valid_q);
    assign rd_fire   = arready_q & s_axil.arvalid;

    assign wmask   = {{8{s_axil.wstrb[3]}}, {8{s_axil.wstrb[2]}},
                      {8{s_axil.wstrb[1]}}, {8{s_axil.wstrb[0]}}};
    assign ps_data = s_axil.wdata & wmask;

`ifdef AXIL_REGFILE_DECERR_EN
    logic wr_in_range, rd_in_range;
    assign wr_in_range = ({1'b0, wr_idx} < (IDX_W+1)'(NUM_REGS));
    assign rd_in_range = ({1'b0, rd_idx} < (IDX_W+1)'(NUM_REGS));
    assign wr_resp     = wr_in_range ? 2'b00 : 2'b10;
    assign rd_resp     = rd_in_range ? 2'b00 : 2'b10;
`else
    assign wr_resp = 2'b00;
    assign rd_resp = 2'b00;
`endif

    // Protection bits and byte-offset address bits carry no meaning for word registers.
    assign unused_bits = ^{s_axil.awprot, s_axil.arprot, s_axil.awaddr[1:0], s_axil.araddr[1:0]};

    assign s_axil.awready = awready_q;
    assign s_axil.wready  = awready_q;
    assign s_axil.bvalid  = bvalid_q;
    assign s_axil.bresp   = bresp_q;
    assign s_axil.arready = arready_q;
    assign s_axil.rvalid  = rvalid_q;
    assign s_axil.rdata   = rdata_q;
    assign s_axil.rresp   = rresp_q;

    assign ps_wr_pulse = ps_wr_pulse_q;
    assign irq         = irq_q;

    // Flatten the register array onto the PL-facing bus
    always_comb begin
        reg_q = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            reg_q[32*i +: 32] = regs_q[i];
        end
    end

    // Decode which register a committing PS write targets; out-of-range selects none
    always_comb begin
        ps_sel = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            ps_sel[i] = wr_fire && (wr_idx == IDX_W'(i));
        end
    end

    // Read mux: samples the current (pre-write) value; out-of-range returns zero
    always_comb begin
        rd_word = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (rd_idx == IDX_W'(i)) rd_word = regs_q[i];
        end
    end

    // Per-register next state by type: W1C set-wins-clear, RO PL-only, RW PS-over-PL
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and a latch is never inferred.
        regs_d        = regs_q;
        ps_wr_pulse_d = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (W1C_MASK[i]) begin
                regs_d[i] = (regs_q[i] & ~(ps_sel[i] ? ps_data : 32'h0))
                          | (pl_wr_en[i] ? pl_wr_data[32*i +: 32] : 32'h0);
                ps_wr_pulse_d[i] = ps_sel[i] & (|s_axil.wstrb);
            end else if (RO_MASK[i]) begin
                if (pl_wr_en[i]) regs_d[i] = pl_wr_data[32*i +: 32];
            end else begin
                if (ps_sel[i] && (|s_axil.wstrb)) begin
                    regs_d[i]        = (regs_q[i] & ~wmask) | ps_data;
                    ps_wr_pulse_d[i] = 1'b1;
                end else if (pl_wr_en[i]) begin
                    regs_d[i] = pl_wr_data[32*i +: 32];
                end
            end
        end
    end

    // Write channel: ready pulse, response raised on commit and held until bready
    always_comb begin
        awready_d = wr_accept;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        if (wr_fire) begin
            bvalid_d = 1'b1;
            bresp_d  = wr_resp;
        end else if (s_axil.bready) begin
            bvalid_d = 1'b0;
        end
    end

    // Read channel: one-cycle latency, or two through the s1 stage when pipelined
    always_comb begin
        arready_d  = rd_accept;
        rvalid_d   = rvalid_q;
        rdata_d    = rdata_q;
        rresp_d    = rresp_q;
        s1_valid_d = s1_valid_q;
        s1_data_d  = s1_data_q;
        s1_resp_d  = s1_resp_q;
        if (PIPE) begin
            if (s1_valid_q && out_free) begin
                rvalid_d   = 1'b1;
                rdata_d    = s1_data_q;
                rresp_d    = s1_resp_q;
                s1_valid_d = 1'b0;
            end else if (s_axil.rready) begin
                rvalid_d = 1'b0;
            end
            if (rd_fire) begin
                s1_valid_d = 1'b1;
                s1_data_d  = rd_word;
                s1_resp_d  = rd_resp;
            end
        end else begin
            if (rd_fire) begin
                rvalid_d = 1'b1;
                rdata_d  = rd_word;
                rresp_d  = rd_resp;
            end else if (s_axil.rready) begin
                rvalid_d = 1'b0;
            end
        end
    end

    // Interrupt from the current status and enable registers, one cycle behind them
    assign irq_d = |(regs_q[IRQ_STS_IDX] & regs_q[IRQ_ENA_IDX]);

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values regardless of statement order.
        if (rst) begin
            // NOTE: the register array is reset because its contents are architecturally visible on reg_q and the bus.
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
            awready_q     <= 1'b0;
            bvalid_q      <= 1'b0;
            bresp_q       <= 2'b00;
            arready_q     <= 1'b0;
            rvalid_q      <= 1'b0;
            rdata_q       <= '0;
            rresp_q       <= 2'b00;
            s1_valid_q    <= 1'b0;
            s1_data_q     <= '0;
            s1_resp_q     <= 2'b00;
            ps_wr_pulse_q <= '0;
            irq_q         <= 1'b0;
        end else begin
            regs_q        <= regs_d;
            awready_q     <= awready_d;
            bvalid_q      <= bvalid_d;
            bresp_q       <= bresp_d;
            arready_q     <= arready_d;
            rvalid_q      <= rvalid_d;
            rdata_q       <= rdata_d;
            rresp_q       <= rresp_d;
            s1_valid_q    <= s1_valid_d;
            s1_data_q     <= s1_data_d;
            s1_resp_q     <= s1_resp_d;
            ps_wr_pulse_q <= ps_wr_pulse_d;
            irq_q         <= irq_d;
        end
    end
endmodule

// File: tb/tb_axil_ctrl_regfile.sv
// Directed bench for axil_ctrl_regfile: reg 0 W1C status, reg 1 RW enable, reg 4 RO.
// dut0 has a plain R channel, dut1 the pipelined one; both share clk, rst and the PL ports.
module tb_axil_ctrl_regfile;
    localparam int NR = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic [NR-1:0]    pl_wr_en;
    logic [32*NR-1:0] pl_wr_data;
    logic [32*NR-1:0] reg_q0, reg_q1;
    logic [NR-1:0]    pulse0, pulse1;
    logic             irq0, irq1;

    int n_cmp = 0;
    int n_err = 0;

    // Read-channel master signals per DUT (index 0 = dut0, 1 = dut1)
    logic [1:0]  ar_valid, r_ready;
    logic [7:0]  ar_addr [2];
    logic [1:0]  arready_w, rvalid_w;
    logic [31:0] rdata_w [2];
    logic [1:0]  rresp_w [2];

    axil_ctrl_regfile_if #(.ADDR_WIDTH(8)) bus0 ();
    axil_ctrl_regfile_if #(.ADDR_WIDTH(8)) bus1 ();

    assign bus0.arvalid = ar_valid[0];
    assign bus0.araddr  = ar_addr[0];
    assign bus0.rready  = r_ready[0];
    assign bus0.arprot  = 3'b000;
    assign bus1.arvalid = ar_valid[1];
    assign bus1.araddr  = ar_addr[1];
    assign bus1.rready  = r_ready[1];
    assign bus1.arprot  = 3'b000;
    assign bus1.awaddr  = 8'h00;
    assign bus1.awprot  = 3'b000;
    assign bus1.awvalid = 1'b0;
    assign bus1.wdata   = 32'h0;
    assign bus1.wstrb   = 4'h0;
    assign bus1.wvalid  = 1'b0;
    assign bus1.bready  = 1'b1;

    assign arready_w = {bus1.arready, bus0.arready};
    assign rvalid_w  = {bus1.rvalid,  bus0.rvalid};
    assign rdata_w[0] = bus0.rdata;
    assign rdata_w[1] = bus1.rdata;
    assign rresp_w[0] = bus0.rresp;
    assign rresp_w[1] = bus1.rresp;

    axil_ctrl_regfile #(
        .ADDR_WIDTH(8), .NUM_REGS(NR), .RO_MASK(64'h10), .W1C_MASK(64'h1),
        .IRQ_STS_IDX(0), .IRQ_ENA_IDX(1), .PIPELINE_OUTPUT(0)
    ) dut0 (
        .clk(clk), .rst(rst), .s_axil(bus0), .pl_wr_en(pl_wr_en), .pl_wr_data(pl_wr_data),
        .reg_q(reg_q0), .ps_wr_pulse(pulse0), .irq(irq0)
    );

    axil_ctrl_regfile #(
        .ADDR_WIDTH(8), .NUM_REGS(NR), .RO_MASK(64'h10), .W1C_MASK(64'h1),
        .IRQ_STS_IDX(0), .IRQ_ENA_IDX(1), .PIPELINE_OUTPUT(1)
    ) dut1 (
        .clk(clk), .rst(rst), .s_axil(bus1), .pl_wr_en(pl_wr_en), .pl_wr_data(pl_wr_data),
        .reg_q(reg_q1), .ps_wr_pulse(pulse1), .irq(irq1)
    );

    always #5 clk = ~clk;

`ifdef AXIL_REGFILE_DECERR_EN
    localparam logic [1:0] OOR_RESP = 2'b10;
`else
    localparam logic [1:0] OOR_RESP = 2'b00;
`endif

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One-cycle PL write of a single word
    task automatic pl_write(input int idx, input logic [31:0] dat);
        pl_wr_en[idx]            = 1'b1;
        pl_wr_data[32*idx +: 32] = dat;
        tick();
        pl_wr_en   = '0;
        pl_wr_data = '0;
    endtask

    // PS write on dut0; optional PL write lands in the same commit cycle.
    // Returns just after the commit edge with bresp and ps_wr_pulse sampled.
    task automatic axi_write(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input logic [NR-1:0] pl_en, input int pl_idx, input logic [31:0] pl_dat,
                             output logic [1:0] resp, output logic [NR-1:0] pulse);
        int n;
        bus0.awaddr  = addr;
        bus0.wdata   = data;
        bus0.wstrb   = strb;
        bus0.awvalid = 1'b1;
        bus0.wvalid  = 1'b1;
        n = 0;
        while (!bus0.awready && n < 20) begin
            tick();
            n++;
        end
        check("awready", 32'(bus0.awready), 32'd1);
        pl_wr_en = pl_en;
        if (pl_en != '0) pl_wr_data[32*pl_idx +: 32] = pl_dat;
        tick();
        bus0.awvalid = 1'b0;
        bus0.wvalid  = 1'b0;
        pl_wr_en     = '0;
        pl_wr_data   = '0;
        check("bvalid", 32'(bus0.bvalid), 32'd1);
        resp  = bus0.bresp;
        pulse = pulse0;
    endtask

    // Issue an AR on DUT d and wait for the R beat; rready is left as the caller set it.
    task automatic axi_read(input int d, input logic [7:0] addr,
                            output logic [31:0] data, output logic [1:0] resp);
        int n;
        ar_addr[d]  = addr;
        ar_valid[d] = 1'b1;
        n = 0;
        while (!arready_w[d] && n < 20) begin
            tick();
            n++;
        end
        check("arready", 32'(arready_w[d]), 32'd1);
        tick();
        ar_valid[d] = 1'b0;
        n = 0;
        while (!rvalid_w[d] && n < 20) begin
            tick();
            n++;
        end
        check("rvalid", 32'(rvalid_w[d]), 32'd1);
        data = rdata_w[d];
        resp = rresp_w[d];
    endtask

    // Back-pressure on R: second AR must stall until rready, data must hold.
    task automatic read_stall(input int d);
        logic [31:0] data;
        logic [1:0]  resp;
        r_ready[d] = 1'b0;
        axi_read(d, 8'h14, data, resp);
        check("stall_first_data", data, 32'h1111_5555);
        ar_addr[d]  = 8'h18;
        ar_valid[d] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("stall_arready_low", 32'(arready_w[d]), 32'd0);
            check("stall_rvalid_held", 32'(rvalid_w[d]), 32'd1);
            check("stall_rdata_held", rdata_w[d], 32'h1111_5555);
        end
        r_ready[d] = 1'b1;
        tick();
        check("stall_arready_release", 32'(arready_w[d]), 32'd1);
        tick();
        ar_valid[d] = 1'b0;
        check("stall_latency", 32'(rvalid_w[d]), (d == 0) ? 32'd1 : 32'd0);
        if (d == 1) begin
            tick();
            check("stall_latency_pipe", 32'(rvalid_w[d]), 32'd1);
        end
        check("stall_second_data", rdata_w[d], 32'h6666_AAAA);
        tick();
    endtask

    initial begin
        logic [31:0]   data;
        logic [1:0]    resp;
        logic [NR-1:0] pulse;

        rst          = 1'b1;
        pl_wr_en     = '0;
        pl_wr_data   = '0;
        ar_valid     = '0;
        r_ready      = 2'b11;
        ar_addr[0]   = 8'h00;
        ar_addr[1]   = 8'h00;
        bus0.awaddr  = 8'h00;
        bus0.awprot  = 3'b000;
        bus0.awvalid = 1'b0;
        bus0.wdata   = 32'h0;
        bus0.wstrb   = 4'h0;
        bus0.wvalid  = 1'b0;
        bus0.bready  = 1'b1;
        repeat (3) tick();

        // Reset state
        check("rst_reg0", reg_q0[31:0], 32'h0);
        check("rst_reg2", reg_q0[95:64], 32'h0);
        check("rst_hs", {28'h0, bus0.awready, bus0.bvalid, bus0.arready, bus0.rvalid}, 32'h0);
        check("rst_rdata", bus0.rdata, 32'h0);
        check("rst_pulse_irq", {15'h0, irq0, 16'(pulse0)}, 32'h0);
        rst = 1'b0;
        tick();

        // 1: byte strobes on RW reg 2, pulse lasts one cycle
        axi_write(8'h08, 32'hDEAD_BEEF, 4'b0011, '0, 0, 32'h0, resp, pulse);
        check("t1_bresp", 32'(resp), 32'd0);
        check("t1_pulse", 32'(pulse), 32'h0000_0004);
        tick();
        check("t1_pulse_off", 32'(pulse0), 32'h0);
        axi_read(0, 8'h08, data, resp);
        check("t1_readback", data, 32'h0000_BEEF);
        check("t1_rresp", 32'(resp), 32'd0);

        // 2: PS beats PL on RW reg 3; PL wins on RO reg 4, PS still answered OKAY
        axi_write(8'h0C, 32'h5, 4'hF, NR'(1 << 3), 3, 32'h7, resp, pulse);
        check("t2_rw_pulse", 32'(pulse), 32'h0000_0008);
        check("t2_rw_reg3", reg_q0[127:96], 32'h5);
        axi_write(8'h10, 32'h5, 4'hF, NR'(1 << 4), 4, 32'h7, resp, pulse);
        check("t2_ro_reg4", reg_q0[159:128], 32'h7);
        check("t2_ro_bresp", 32'(resp), 32'd0);
        check("t2_ro_pulse", 32'(pulse), 32'h0);

        // 3: W1C set wins over clear, then a lone clear
        pl_write(0, 32'h3);
        check("t3_w1c_set", reg_q0[31:0], 32'h3);
        axi_write(8'h00, 32'h1, 4'hF, NR'(1), 0, 32'h1, resp, pulse);
        check("t3_set_wins", reg_q0[31:0], 32'h3);
        axi_write(8'h00, 32'h1, 4'hF, '0, 0, 32'h0, resp, pulse);
        check("t3_clear", reg_q0[31:0], 32'h2);

        // 4: interrupt one cycle behind status/enable
        axi_write(8'h04, 32'h1, 4'hF, '0, 0, 32'h0, resp, pulse);
        check("t4_ena", reg_q0[63:32], 32'h1);
        tick();
        check("t4_irq_idle", 32'(irq0), 32'd0);
        pl_write(0, 32'h1);
        check("t4_sts_set", reg_q0[31:0], 32'h3);
        check("t4_irq_lag", 32'(irq0), 32'd0);
        tick();
        check("t4_irq_on", 32'(irq0), 32'd1);
        axi_write(8'h00, 32'h1, 4'hF, '0, 0, 32'h0, resp, pulse);
        check("t4_sts_clr", reg_q0[31:0], 32'h2);
        check("t4_irq_hold", 32'(irq0), 32'd1);
        tick();
        check("t4_irq_off", 32'(irq0), 32'd0);

        // 5: R-channel back-pressure on both output variants
        pl_write(5, 32'h1111_5555);
        pl_write(6, 32'h6666_AAAA);
        read_stall(0);
        read_stall(1);

        // 6: out-of-range accesses
        axi_read(0, 8'h40, data, resp);
        check("t6_oor_rdata", data, 32'h0);
        check("t6_oor_rresp", 32'(resp), 32'(OOR_RESP));
        axi_write(8'h40, 32'hFFFF_FFFF, 4'hF, '0, 0, 32'h0, resp, pulse);
        check("t6_oor_bresp", 32'(resp), 32'(OOR_RESP));
        check("t6_oor_pulse", 32'(pulse), 32'h0);
        check("t6_oor_reg2", reg_q0[95:64], 32'h0000_BEEF);

        // 6: reset with a response pending drops it
        r_ready[0] = 1'b0;
        axi_read(0, 8'h08, data, resp);
        check("t6_pend_data", data, 32'h0000_BEEF);
        rst = 1'b1;
        tick();
        check("t6_rst_rvalid", 32'(rvalid_w[0]), 32'd0);
        check("t6_rst_reg2", reg_q0[95:64], 32'h0);
        rst        = 1'b0;
        r_ready[0] = 1'b1;
        tick();
        check("t6_rvalid_stays", 32'(rvalid_w[0]), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
